// File: rtl/masked_pkg.sv
// Shared elaboration-time helpers for the N-share boolean unmasking pipeline:
// layer count, per-layer share counts and where each layer's randomness lives in i_n.
package masked_pkg;

   localparam int MIN_SHARES = 2;

   function automatic int layers(input int n);
      return $clog2(n);
   endfunction

   // Share count held by layer l; each layer halves (rounding up) the previous one.
   function automatic int shares_at(input int n, input int l);
      int m;
      m = n;
      for (int i = 0; i < l; i++) begin
         m = (m + 1) / 2;
      end
      return m;
   endfunction

   // A 2-share refresh needs a single word; wider layers use a ring of m words.
   function automatic int words_at(input int m);
      return (m == 2) ? 1 : m;
   endfunction

   function automatic int rand_offset(input int n, input int l);
      int s;
      s = 0;
      for (int i = 0; i < l; i++) begin
         s += words_at(shares_at(n, i));
      end
      return s;
   endfunction

   function automatic int rand_words(input int n);
      return rand_offset(n, layers(n));
   endfunction

endpackage

// File: rtl/masked_refresh_layer.sv
// One compress-and-refresh register layer of the unmasking pipeline.
// Invalid items load all-zero shares so no stale mask material lingers in the registers.
module masked_refresh_layer
   import masked_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int M_IN     = 3,
   parameter bit COMPRESS = 1'b0
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               en,
   input  logic                                               flush,
   input  logic                                               up_vld,
   input  logic [M_IN*K_WIDTH-1:0]                            up_sh,
   input  logic [words_at(COMPRESS ? (M_IN+1)/2 : M_IN)*K_WIDTH-1:0] rnd,
   output logic                                               vld,
   output logic [(COMPRESS ? (M_IN+1)/2 : M_IN)*K_WIDTH-1:0]  sh
);

   localparam int M = COMPRESS ? (M_IN + 1) / 2 : M_IN;

   logic [M*K_WIDTH-1:0] nxt;

   for (genvar j = 0; j < M; j++) begin : g_share
      logic [K_WIDTH-1:0] c;
      logic [K_WIDTH-1:0] f;

      // Pairwise fold; an odd trailing share is carried over untouched.
      if (COMPRESS && (2*j + 1 < M_IN)) begin : g_pair
         assign c = up_sh[2*j*K_WIDTH +: K_WIDTH] ^ up_sh[(2*j+1)*K_WIDTH +: K_WIDTH];
      end else if (COMPRESS) begin : g_odd
         assign c = up_sh[2*j*K_WIDTH +: K_WIDTH];
      end else begin : g_raw
         assign c = up_sh[j*K_WIDTH +: K_WIDTH];
      end

      // Each word enters exactly two shares, so the XOR of all shares is preserved.
      if (M == 2) begin : g_two
         assign f = c ^ rnd[K_WIDTH-1:0];
      end else begin : g_ring
         assign f = c ^ rnd[j*K_WIDTH +: K_WIDTH] ^ rnd[((j + M - 1) % M)*K_WIDTH +: K_WIDTH];
      end

      assign nxt[j*K_WIDTH +: K_WIDTH] = f;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= 1'b0;
         sh  <= '0;
      end else if (flush) begin
         vld <= 1'b0;
         sh  <= '0;
      end else if (en) begin
         vld <= up_vld;
         sh  <= up_vld ? nxt : '0;
      end
   end

endmodule

// File: rtl/masked_unmask_pipe.sv
// Recombines an N-share boolean-masked word into its plain value through log2(N)
// refresh-and-compress layers; the whole pipe advances in lockstep under one enable.
module masked_unmask_pipe
   import masked_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 3,
   localparam int LAYERS  = layers(N_SHARES),
   localparam int RANDNUM = rand_words(N_SHARES)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          i_flush,
   input  logic                          i_dvld,
   output logic                          o_drdy,
   input  logic [K_WIDTH*N_SHARES-1:0]   i_x,
   input  logic                          i_rvld,
   input  logic [K_WIDTH*RANDNUM-1:0]    i_n,
   output logic [K_WIDTH-1:0]            o_z,
   output logic                          o_dvld,
   input  logic                          i_drdy,
   output logic                          o_busy
);

   if (N_SHARES < MIN_SHARES) begin : g_bad_shares
      $error("masked_unmask_pipe: N_SHARES must be at least 2");
   end

   logic              en;
   logic [LAYERS-1:0] vld_l;

   // Without fresh randomness nothing may move, not even bubbles.
   assign en     = ~rst_i & i_rvld & ~i_flush & (~o_dvld | i_drdy);
   assign o_drdy = en;

   for (genvar l = 0; l < LAYERS; l++) begin : g_layer
      localparam int M   = shares_at(N_SHARES, l);
      localparam int OFS = rand_offset(N_SHARES, l);

      logic [M*K_WIDTH-1:0] sh;

      if (l == 0) begin : g_first
         masked_refresh_layer #(
            .K_WIDTH  (K_WIDTH),
            .M_IN     (N_SHARES),
            .COMPRESS (1'b0)
         ) u_layer (
            .clk    (clk_i),
            .rst    (rst_i),
            .en     (en),
            .flush  (i_flush),
            .up_vld (i_dvld),
            .up_sh  (i_x),
            .rnd    (i_n[OFS*K_WIDTH +: words_at(M)*K_WIDTH]),
            .vld    (vld_l[l]),
            .sh     (sh)
         );
      end else begin : g_next
         masked_refresh_layer #(
            .K_WIDTH  (K_WIDTH),
            .M_IN     (shares_at(N_SHARES, l - 1)),
            .COMPRESS (1'b1)
         ) u_layer (
            .clk    (clk_i),
            .rst    (rst_i),
            .en     (en),
            .flush  (i_flush),
            .up_vld (vld_l[l-1]),
            .up_sh  (g_layer[l-1].sh),
            .rnd    (i_n[OFS*K_WIDTH +: words_at(M)*K_WIDTH]),
            .vld    (vld_l[l]),
            .sh     (sh)
         );
      end
   end

   // The last layer always holds two shares; folding them yields the secret.
   assign o_z    = g_layer[LAYERS-1].sh[0 +: K_WIDTH] ^ g_layer[LAYERS-1].sh[K_WIDTH +: K_WIDTH];
   assign o_dvld = vld_l[LAYERS-1];
   assign o_busy = |vld_l;

endmodule
